ex_stage_ctrl: RTL and testbench
================================

// Module: ex_stage_ctrl
// PURPOSE
//  Parametrised execute-stage controller for the RV32IM pipeline: decodes the ID/EX control bundle into ALU,
//  result-mux and PC-mux selects, and resolves branches and jumps into a flush request.
//  Adds a sequencer for multi-cycle M-extension ops that stalls the front end until the result is ready.
//  Sits between the ID/EX register and the EX datapath muxes; stall/flush go to the hazard unit.
// PARAMETERS
//  XLEN       32  datapath width (documentation/stat sizing only; no XLEN-wide datapath here)
//  MUL_CYCLES 4   BUSY cycles for MUL (>=1)
//  DIV_CYCLES 32  BUSY cycles for DIV/REM (>=1)
//  STAT_W     16  width of branch statistics counters (BRANCH_STATS_EN only)
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  in_valid     in   1  ID/EX holds a valid instruction
//  kill         in   1  trap/flush from a later stage; aborts the current EX instruction
//  ex           in   3  ALU operation code from decode
//  jump_t       in   2  00 none, 01 JAL, 10 JALR, 11 BRANCH
//  funct3       in   3  branch condition
//  slt, lui     in   1  result-select hints
//  md_op        in   2  00 none, 01 MUL, 10 DIV, 11 REM
//  zero,sign_bit,carry in 1 ALU flags of rs1-rs2 (carry=1 means unsigned borrow)
//  alu_op       out  3  ALU control (= ex)
//  res_sel      out  2  00 ALU, 01 LUI imm, 10 SLT, 11 MD result
//  pc_sel       out  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR)
//  flush        out  1  squash IF/ID and ID/EX (combinational)
//  stall        out  1  hold PC, IF/ID and ID/EX (combinational)
//  md_start     out  1  one-cycle start pulse to the MD unit
//  md_done      out  1  MD result valid this cycle
// BEHAVIOUR
//  - Reset: FSM=IDLE, count=0. Combinational outputs follow: stall=flush=md_start=md_done=0.
//  - res_sel: md_op!=0 -> 11, else slt -> 10, else lui -> 01, else 00.
//  - Branch cond: 000 zero, 001 !zero, 100 sign_bit, 101 !sign_bit, 110 carry, 111 !carry; 010/011 never taken.
//  - taken = in_valid & !kill & (jump_t==JAL | jump_t==JALR | (jump_t==BRANCH & cond)).
//  - pc_sel = JALR&taken -> 10; (JAL|BRANCH)&taken -> 01; else 00. flush = taken & !stall.
//  - MD FSM (IDLE, BUSY, DONE), count width clog2(max(MUL_CYCLES,DIV_CYCLES))+1:
//    IDLE: in_valid & md_op!=0 & !kill -> md_start=1, count<=N-1 (N per op), next BUSY.
//    BUSY: count==0 -> DONE, else count<=count-1.
//    DONE: md_done=1, next IDLE; the instruction leaves EX at the end of this cycle.
//  - stall = in_valid & md_op!=0 & !kill & state!=DONE. MD instr occupies EX for N+2 cycles, N+1 stalled.
//  - Back-to-back MD ops: second seen in IDLE the cycle after DONE; no bubble inserted.
//  - kill in any state: FSM -> IDLE next edge, stall=flush=md_start=0 that cycle; kill wins over taken.
//  - jump_t!=00 with md_op!=00 is illegal decode; md path has priority, flush suppressed while stalled.
//  - Reset asserted mid-op: immediate IDLE, stall released asynchronously.
// CONFIGURATION
//  BRANCH_STATS_EN defined: extra outputs br_taken_cnt, br_nt_cnt [STAT_W-1:0], reset 0; increment on each
//    cycle with in_valid & !kill & !stall & jump_t==BRANCH (taken/not-taken); saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  BEQ, zero=1, in_valid=1 -> pc_sel=01, flush=1 same cycle; zero=0 -> pc_sel=00, flush=0.
//  BLTU carry=1 / BGEU carry=1 -> taken / not taken; funct3=010 BRANCH -> never taken.
//  MUL, MUL_CYCLES=4 -> md_start pulse cycle 0, stall=1 cycles 0..4, md_done=1 & stall=0 cycle 5, res_sel=11.
//  DIV then MUL back-to-back -> 34 + 6 cycles total, second md_start the cycle after first md_done.
//  kill in BUSY cycle 2 of DIV -> stall=0 that cycle, IDLE next; rst_n low mid-BUSY -> stall 0 at once.
//  BRANCH_STATS_EN, STAT_W=2: 5 taken branches -> br_taken_cnt=3 (saturated), br_nt_cnt=0.

Source files
------------

// File: rtl/ex_stage_ctrl.sv
// Execute-stage controller: decodes ALU/result/PC selects, resolves branches and
// jumps into a flush request, and sequences multi-cycle MUL/DIV/REM operations by
// stalling the front end until the result is ready.
// Optional feature: define BRANCH_STATS_EN to add saturating branch taken/not-taken
// counters (br_taken_cnt, br_nt_cnt).
module ex_stage_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              kill,
    input  logic [2:0]        ex,
    input  logic [1:0]        jump_t,
    input  logic [2:0]        funct3,
    input  logic              slt,
    input  logic              lui,
    input  logic [1:0]        md_op,
    input  logic              zero,
    input  logic              sign_bit,
    input  logic              carry,
    output logic [2:0]        alu_op,
    output logic [1:0]        res_sel,
    output logic [1:0]        pc_sel,
    output logic              flush,
    output logic              stall,
    output logic              md_start,
    output logic              md_done
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] br_taken_cnt,
    output logic [STAT_W-1:0] br_nt_cnt
`endif
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    localparam logic [1:0] JumpJal    = 2'b01;
    localparam logic [1:0] JumpJalr   = 2'b10;
    localparam logic [1:0] JumpBranch = 2'b11;
    localparam logic [1:0] MdMul      = 2'b01;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] count_q;
    logic            cond;
    logic            taken;
    logic            md_req;

    // Branch condition from the rs1-rs2 ALU flags.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = sign_bit;
            3'b101:  cond = ~sign_bit;
            3'b110:  cond = carry;
            3'b111:  cond = ~carry;
            default: cond = 1'b0;
        endcase
    end

    // Decode selects, control-flow resolution and MD handshake outputs.
    // Outputs are gated with rst_n so they read zero while reset is held.
    always_comb begin
        md_req = in_valid & (md_op != 2'b00) & ~kill;
        taken  = in_valid & ~kill &
                 ((jump_t == JumpJal) | (jump_t == JumpJalr) | ((jump_t == JumpBranch) & cond));

        alu_op = ex;

        if (md_op != 2'b00) begin
            res_sel = 2'b11;
        end else if (slt) begin
            res_sel = 2'b10;
        end else if (lui) begin
            res_sel = 2'b01;
        end else begin
            res_sel = 2'b00;
        end

        pc_sel = 2'b00;
        if (taken) begin
            if (jump_t == JumpJalr) begin
                pc_sel = 2'b10;
            end else begin
                pc_sel = 2'b01;
            end
        end

        // An MD op holds EX until its DONE cycle; a jump decoded alongside it is
        // illegal and its flush stays suppressed while stalled.
        stall    = rst_n & md_req & (state_q != StDone);
        md_start = rst_n & md_req & (state_q == StIdle);
        md_done  = rst_n & (state_q == StDone);
        flush    = rst_n & taken & ~stall;
    end

    // MD sequencer: load the per-op cycle count on start, count down, then DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
        end else if (kill) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (md_req) begin
                        count_q <= (md_op == MdMul) ? MulLoad : DivLoad;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (count_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic br_retire;
    assign br_retire = in_valid & ~kill & ~stall & (jump_t == JumpBranch);

    // Saturating counters of retired conditional branches, split by outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt <= '0;
            br_nt_cnt    <= '0;
        end else if (br_retire) begin
            if (taken) begin
                if (br_taken_cnt != '1) br_taken_cnt <= br_taken_cnt + 1'b1;
            end else begin
                if (br_nt_cnt != '1) br_nt_cnt <= br_nt_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed self-checking bench for ex_stage_ctrl (default MUL_CYCLES=4, DIV_CYCLES=32).
// With BRANCH_STATS_EN defined, the DUT is built with STAT_W=2 and saturation is checked.
module tb_ex_stage_ctrl;

`ifdef BRANCH_STATS_EN
    localparam int unsigned StatW = 2;
`else
    localparam int unsigned StatW = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, kill, slt, lui, zero, sign_bit, carry;
    logic [2:0] ex, funct3;
    logic [1:0] jump_t, md_op;
    logic [2:0] alu_op;
    logic [1:0] res_sel, pc_sel;
    logic       flush, stall, md_start, md_done;
`ifdef BRANCH_STATS_EN
    logic [StatW-1:0] br_taken_cnt, br_nt_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int n1, n2;

    ex_stage_ctrl #(
        .XLEN      (32),
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .STAT_W    (StatW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .kill    (kill),
        .ex      (ex),
        .jump_t  (jump_t),
        .funct3  (funct3),
        .slt     (slt),
        .lui     (lui),
        .md_op   (md_op),
        .zero    (zero),
        .sign_bit(sign_bit),
        .carry   (carry),
        .alu_op  (alu_op),
        .res_sel (res_sel),
        .pc_sel  (pc_sel),
        .flush   (flush),
        .stall   (stall),
        .md_start(md_start),
        .md_done (md_done)
`ifdef BRANCH_STATS_EN
        ,
        .br_taken_cnt(br_taken_cnt),
        .br_nt_cnt   (br_nt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; slt = 1'b0; lui = 1'b0;
        zero = 1'b0; sign_bit = 1'b0; carry = 1'b0; ex = 3'd0; funct3 = 3'd0;
        jump_t = 2'b00; md_op = 2'b00;

        // Reset state
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_done", md_done, 0);
        next; rst_n = 1'b1;

        // BEQ taken / not taken
        next; in_valid = 1'b1; jump_t = 2'b11; funct3 = 3'b000; zero = 1'b1; #1;
        chk("beq_t_pc", pc_sel, 2'b01);
        chk("beq_t_flush", flush, 1);
        zero = 1'b0; #1;
        chk("beq_nt_pc", pc_sel, 2'b00);
        chk("beq_nt_flush", flush, 0);

        // BLTU / BGEU with borrow
        funct3 = 3'b110; carry = 1'b1; #1;
        chk("bltu_flush", flush, 1);
        funct3 = 3'b111; #1;
        chk("bgeu_flush", flush, 0);

        // funct3=010 never taken even with every flag set
        funct3 = 3'b010; zero = 1'b1; sign_bit = 1'b1; #1;
        chk("f010_flush", flush, 0);
        chk("f010_pc", pc_sel, 2'b00);
        zero = 1'b0; sign_bit = 1'b0; carry = 1'b0;

        // JALR / JAL
        jump_t = 2'b10; #1;
        chk("jalr_pc", pc_sel, 2'b10);
        chk("jalr_flush", flush, 1);
        jump_t = 2'b01; #1;
        chk("jal_pc", pc_sel, 2'b01);

        // kill wins over taken
        kill = 1'b1; #1;
        chk("kill_jal_flush", flush, 0);
        chk("kill_jal_pc", pc_sel, 2'b00);
        kill = 1'b0; jump_t = 2'b00;

        // Result select priority and ALU pass-through
        ex = 3'd5; slt = 1'b1; lui = 1'b1; #1;
        chk("alu_op", alu_op, 3'd5);
        chk("res_slt", res_sel, 2'b10);
        slt = 1'b0; #1;
        chk("res_lui", res_sel, 2'b01);
        lui = 1'b0; #1;
        chk("res_alu", res_sel, 2'b00);

        // MUL, with an illegal JAL alongside in cycle 0 (flush must stay low)
        next; md_op = 2'b01; jump_t = 2'b01; #1;
        chk("mul_c0_start", md_start, 1);
        chk("mul_c0_stall", stall, 1);
        chk("mul_c0_flush", flush, 0);
        chk("mul_res_sel", res_sel, 2'b11);
        jump_t = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            next;
            chk($sformatf("mul_c%0d_stall", c), stall, (c < 5) ? 1 : 0);
            chk($sformatf("mul_c%0d_start", c), md_start, 0);
            chk($sformatf("mul_c%0d_done", c), md_done, (c == 5) ? 1 : 0);
        end

        // DIV then MUL back-to-back
        next; md_op = 2'b10; #1;
        chk("div_start", md_start, 1);
        n1 = 0;
        while (!md_done && n1 < 100) begin
            next; n1++;
        end
        chk("div_done_cycle", n1[15:0], 16'd33);
        next; md_op = 2'b01; #1;
        chk("b2b_mul_start", md_start, 1);
        n2 = 0;
        while (!md_done && n2 < 100) begin
            next; n2++;
        end
        chk("b2b_mul_done_cycle", n2[15:0], 16'd5);
        chk("b2b_total", 16'(n1 + n2 + 2), 16'd40);
        next; in_valid = 1'b0; md_op = 2'b00;

        // kill in BUSY cycle 2 of a DIV
        next; in_valid = 1'b1; md_op = 2'b10; #1;
        chk("kdiv_start", md_start, 1);
        next;
        next; kill = 1'b1; #1;
        chk("kdiv_kill_stall", stall, 0);
        chk("kdiv_kill_start", md_start, 0);
        next; kill = 1'b0; #1;
        chk("kdiv_idle_restart", md_start, 1);

        // Reset mid-BUSY releases stall immediately
        next;
        next; #1;
        chk("rdiv_busy_stall", stall, 1);
        rst_n = 1'b0; #1;
        chk("rdiv_rst_stall", stall, 0);
        chk("rdiv_rst_done", md_done, 0);
        next; rst_n = 1'b1; #1;
        chk("rdiv_idle_start", md_start, 1);
        next; in_valid = 1'b0; md_op = 2'b00;

`ifdef BRANCH_STATS_EN
        // Saturating branch statistics with STAT_W=2
        rst_n = 1'b0;
        next; rst_n = 1'b1;
        next; in_valid = 1'b1; jump_t = 2'b11; funct3 = 3'b000; zero = 1'b1;
        repeat (5) next;
        in_valid = 1'b0; #1;
        chk("stat_taken_sat", 16'(br_taken_cnt), 16'd3);
        chk("stat_nt_zero", 16'(br_nt_cnt), 16'd0);
        in_valid = 1'b1; zero = 1'b0;
        next; in_valid = 1'b0; #1;
        chk("stat_nt_one", 16'(br_nt_cnt), 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
